// File: rtl/bcd_to_bin_pkg.sv
// Shared BCD definitions for the binary/BCD converter pair: nibble width,
// digit limit and the converter FSM encoding.
package bcd_to_bin_pkg;

  localparam int NIBBLE_W  = 4;
  localparam int DIGIT_MAX = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } conv_state_t;

  function automatic logic digit_ok(input logic [NIBBLE_W-1:0] digit);
    return digit <= NIBBLE_W'(DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_nibble_corr.sv
// Reverse double-dabble correction for one BCD nibble: after a right shift a
// nibble holding 8 or more has to be pulled back by 3.
module bcd_nibble_corr
  import bcd_to_bin_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [NIBBLE_W-1:0] corrected
);

  assign corrected = (nibble >= NIBBLE_W'(8)) ? nibble - NIBBLE_W'(3) : nibble;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one bit per
// clock, with an error short-cut for non-decimal digits.
module bcd_to_bin
  import bcd_to_bin_pkg::*;
#(
  parameter int N_DIGITS = 3,
  parameter int BIN_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       cent,
  input  logic [3:0]       dec,
  input  logic [3:0]       un,
  input  logic             start,
  output logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int BCD_W = N_DIGITS * NIBBLE_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_t state_q, state_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d, bcd_corr;
  logic [BIN_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   bad_q, bad_d;
  logic [BIN_W-1:0]       bin_q, bin_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;
  logic [BCD_W+BIN_W-1:0] pair_shift;
  logic                   digits_ok;

  assign digits_ok  = digit_ok(cent) && digit_ok(dec) && digit_ok(un);
  assign pair_shift = {bcd_q, acc_q} >> 1;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_corr
    bcd_nibble_corr u_corr (
      .nibble    (pair_shift[BIN_W + g*NIBBLE_W +: NIBBLE_W]),
      .corrected (bcd_corr[g*NIBBLE_W +: NIBBLE_W])
    );
  end

  // NOTE: every next-state variable takes its hold value first, so no path
  // through the case below can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    bin_d   = bin_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = BCD_W'({cent, dec, un});
          acc_d   = '0;
          cnt_d   = '0;
          bad_d   = !digits_ok;
          state_d = digits_ok ? SHIFT : FINISH;
        end
      end
      SHIFT: begin
        bcd_d = bcd_corr;
        acc_d = pair_shift[BIN_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = FINISH;
      end
      FINISH: begin
        // A rejected request still reports through the same path, with bin=0.
        bin_d   = bad_q ? '0 : acc_q;
        err_d   = bad_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with the control state so a
  // mid-conversion reset leaves no stale partial result anywhere.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // busy spans the done cycle too, giving BIN_W+2 busy cycles per conversion.
  assign busy = (state_q != IDLE) || done_q;
  assign bin  = bin_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed cases, random digit triples
// and an exhaustive 0..999 round trip against an arithmetic model.
module tb_bcd_to_bin;

  localparam int BIN_W  = 10;
  localparam int WINDOW = 16;

  logic             clk;
  logic             reset;
  logic [3:0]       cent, dec, un;
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy, done, err;

  int checks   = 0;
  int failures = 0;

  bcd_to_bin #(.N_DIGITS(3), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .cent  (cent),
    .dec   (dec),
    .un    (un),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request, then watch a fixed window; optionally poke start and
  // the digits while the conversion is running.
  task automatic convert(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u,
                         input bit disturb, output int lat, output int nbusy, output int ndone);
    cent = c; dec = d; un = u; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    nbusy = busy ? 1 : 0;
    ndone = done ? 1 : 0;
    for (int k = 1; k <= WINDOW; k++) begin
      if (disturb && k == 4) begin
        start = 1'b1;
        cent  = 4'($urandom_range(0, 9));
        dec   = 4'($urandom_range(0, 9));
        un    = 4'($urandom_range(0, 9));
      end
      if (disturb && k == 5) start = 1'b0;
      @(posedge clk); #1;
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        lat = k + 1;
      end
    end
  endtask

  task automatic expect_conv(input string tag, input int c, input int d, input int u,
                             input bit disturb, input bit full);
    int  lat, nbusy, ndone, exp_bin, exp_lat;
    bit  ok;
    ok      = (c <= 9) && (d <= 9) && (u <= 9);
    exp_bin = ok ? c * 100 + d * 10 + u : 0;
    exp_lat = ok ? BIN_W + 2 : 2;
    convert(4'(c), 4'(d), 4'(u), disturb, lat, nbusy, ndone);
    check({tag, "_bin"}, 32'(bin), 32'(exp_bin));
    check({tag, "_err"}, 32'(err), ok ? 32'd0 : 32'd1);
    if (full) begin
      check({tag, "_lat"},   32'(lat),   32'(exp_lat));
      check({tag, "_busy"},  32'(nbusy), 32'(exp_lat));
      check({tag, "_ndone"}, 32'(ndone), 32'd1);
    end
  endtask

  initial begin
    int d1, d2, d3;
    int k1, k2;
    reset = 1'b0; start = 1'b0; cent = '0; dec = '0; un = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bin",  32'(bin),  32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err",  32'(err),  32'd0);
    #3 reset = 1'b1;

    expect_conv("c204", 2, 0, 4, 1'b0, 1'b1);
    expect_conv("c999", 9, 9, 9, 1'b0, 1'b1);
    expect_conv("c000", 0, 0, 0, 1'b0, 1'b1);
    expect_conv("bad_dec", 0, 10, 0, 1'b0, 1'b1);
    expect_conv("c123", 1, 2, 3, 1'b0, 1'b1);
    expect_conv("disturb", 6, 4, 7, 1'b1, 1'b1);

    // Start held high across two conversions: second accepted right after the first.
    cent = 4'd4; dec = 4'd5; un = 4'd6; start = 1'b1;
    @(posedge clk); #1;
    cent = 4'd7; dec = 4'd8; un = 4'd9;
    k1 = 0; k2 = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == BIN_W + 2) start = 1'b0;
      if (done && k1 == 0) begin
        k1 = k;
        check("b2b_first_bin", 32'(bin), 32'd456);
      end else if (done && k2 == 0) begin
        k2 = k;
        check("b2b_second_bin", 32'(bin), 32'd789);
      end
    end
    check("b2b_first_at",  32'(k1), 32'(BIN_W + 1));
    check("b2b_spacing",   32'(k2 - k1), 32'(BIN_W + 2));
    repeat (4) @(posedge clk);

    // Reset at shift iteration 5 of a conversion that follows a nonzero result.
    expect_conv("pre_rst", 3, 1, 4, 1'b0, 1'b0);
    cent = 4'd8; dec = 4'd8; un = 4'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_bin",  32'(bin),  32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err",  32'(err),  32'd0);
    #1 reset = 1'b1;
    expect_conv("post_rst", 0, 5, 0, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      d1 = $urandom_range(0, 11);
      d2 = $urandom_range(0, 11);
      d3 = $urandom_range(0, 11);
      expect_conv($sformatf("rnd%0d", i), d1, d2, d3, 1'b0, 1'b1);
    end

    // Round trip: value -> decimal digits (arithmetic BinToBCD) -> DUT.
    for (int v = 0; v < 1000; v++) begin
      expect_conv($sformatf("rt%0d", v), v / 100, (v / 10) % 10, v % 10, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have parameter N_DIGITS, default 3, number of BCD digit nibbles converted.
REQ-002 SHALL have parameter BIN_W, default 10, binary result width; BIN_W >= ceil(log2(10^N_DIGITS)).
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cent  input  4  hundreds digit, BCD.
REQ-006 SHALL have port dec  input  4  tens digit, BCD.
REQ-007 SHALL have port un  input  4  units digit, BCD.
REQ-008 SHALL have port start  input  1  conversion request, level-sampled.
REQ-009 SHALL have port bin  output  BIN_W  binary result, held until the next accepted start.
REQ-010 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when bin/err are valid.
REQ-012 SHALL have port err  output  1  last accepted request had a digit > 9.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, FINISH; only IDLE accepts start.
REQ-014 SHALL, in IDLE with start=1 at edge N, capture {cent,dec,un} into a 12-bit BCD shift register, clear the BIN_W-bit accumulator and iteration counter, and enter SHIFT.
REQ-015 SHALL, in SHIFT, each cycle shift {BCD,acc} right by one bit, then subtract 3 from every BCD nibble whose shifted value is >= 8.
REQ-016 SHALL run exactly BIN_W SHIFT iterations, then enter FINISH.
REQ-017 SHALL, in FINISH, load bin from the accumulator, pulse done for one cycle, clear err, and return to IDLE.
REQ-018 SHALL place done high in the cycle after edge N+BIN_W+1, i.e. latency BIN_W+2 clocks from start sample to done.
REQ-019 SHALL hold busy high from the edge accepting start through the FINISH cycle inclusive.
REQ-020 SHALL ignore start while busy; no queuing, no restart.
REQ-021 SHALL, if any captured digit > 9, skip SHIFT, go directly IDLE->FINISH, load bin=0, set err=1, and pulse done (latency 2 clocks).
REQ-022 SHALL keep err and bin stable between done pulses.
REQ-023 SHALL accept a new start in the first IDLE cycle after FINISH (back-to-back throughput BIN_W+2 clocks).
REQ-024 SHALL sample digit inputs only at start acceptance; input changes during SHIFT have no effect.

Reset
REQ-025 SHALL, on reset low at any time including mid-conversion, immediately force state IDLE, bin=0, busy=0, done=0, err=0, shift register and counter=0.
REQ-026 SHALL not accept start in the first edge after reset deasserts unless reset is high at that edge.

Structure
REQ-027 SHALL take FSM state encoding, BCD nibble width (4) and the digit limit (9) from a shared display/sensor package used with BinToBCD.
REQ-028 SHALL be a single module, with the per-nibble ">=8 subtract 3" correction as an optional sub-module bcd_nibble_corr instantiated N_DIGITS times.
REQ-029 SHALL be synthesizable with no latches and no combinational path from inputs to outputs.

Verification
REQ-030 SHALL check: cent=2,dec=0,un=4, start 1 cycle -> done after 12 clocks, bin=204 (0x0CC), err=0.
REQ-031 SHALL check: 9,9,9 -> bin=999 (0x3E7); 0,0,0 -> bin=0; both with busy high for exactly 12 cycles.
REQ-032 SHALL check: dec=4'hA -> done after 2 clocks, bin=0, err=1; following valid 1,2,3 -> bin=123, err=0.
REQ-033 SHALL check: second start and changed digits during SHIFT -> ignored, result of first request unchanged, single done pulse.
REQ-034 SHALL check: reset low at SHIFT iteration 5 -> all outputs 0 that cycle; post-reset 0,5,0 -> bin=50.
REQ-035 SHALL check: exhaustive round-trip 0..999 through BinToBCD then bcd_to_bin -> bin equals original value, err=0.
